// File: rtl/spi_slave_burst_ram_if.sv
// spi_slave_burst_ram_if: SPI pin bundle (SS_n, MOSI in to slave; MISO, busy out of slave)
interface spi_slave_burst_ram_if;
    logic SS_n;
    logic MOSI;
    logic MISO;
    logic busy;
    modport slave (input SS_n, MOSI, output MISO, busy);
    modport master (output SS_n, MOSI, input MISO, busy);
endinterface

// File: rtl/spi_slave_burst_ram.sv
// spi_slave_burst_ram: SPI slave with burst access to internal RAM (clk, rst_n, bus: SS_n/MOSI in, MISO/busy out)
module spi_slave_burst_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter bit AUTO_INC = 1'b1
) (
    input logic clk,
    input logic rst_n,
    spi_slave_burst_ram_if.slave bus
);
    localparam int W = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;
    localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(AUTO_INC);
    typedef enum logic [2:0] {IDLE, OPC, WADDR, WDATA, RADDR, RDATA, DONE} state_t;
    state_t state, state_nx;
    logic [W-2:0] sh;
    logic [W-1:0] sh_nx;
    logic [CW-1:0] cnt;
    logic [DATA_WIDTH-1:0] tx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic miso, we, load, wa_ld, ra_ld, addr_last, data_last;
    assign sh_nx = {sh, bus.MOSI};
    assign rd_word = mem[rd_ptr];
    assign addr_last = cnt == CW'(ADDR_WIDTH - 1);
    assign data_last = cnt == CW'(DATA_WIDTH - 1);
    assign bus.MISO = miso;
    assign bus.busy = state != IDLE;
    always_comb begin
        state_nx = state;
        we = 1'b0;
        load = 1'b0;
        wa_ld = 1'b0;
        ra_ld = 1'b0;
        case (state)
            IDLE: state_nx = bus.SS_n ? IDLE : OPC;
            OPC: if (cnt == CW'(1)) begin
                state_nx = sh[0] ? (bus.MOSI ? RDATA : RADDR) : (bus.MOSI ? WDATA : WADDR);
                load = sh[0] & bus.MOSI;
            end
            WADDR: begin
                wa_ld = addr_last;
                state_nx = addr_last ? DONE : WADDR;
            end
            RADDR: begin
                ra_ld = addr_last;
                state_nx = addr_last ? DONE : RADDR;
            end
            WDATA: we = data_last;
            RDATA: load = data_last;
            default: ;
        endcase
        if (state != IDLE && bus.SS_n) begin
            state_nx = IDLE;
            we = 1'b0;
            load = 1'b0;
            wa_ld = 1'b0;
            ra_ld = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            miso <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            sh <= '0;
            cnt <= '0;
            tx <= '0;
        end else begin
            state <= state_nx;
            sh <= sh_nx[W-2:0];
            cnt <= (state_nx != state || we || load || state_nx == IDLE || state_nx == DONE) ? '0 : cnt + 1'b1;
            wr_ptr <= wa_ld ? sh_nx[ADDR_WIDTH-1:0] : we ? wr_ptr + INC : wr_ptr;
            rd_ptr <= ra_ld ? sh_nx[ADDR_WIDTH-1:0] : load ? rd_ptr + INC : rd_ptr;
            if (state_nx == IDLE || state_nx == DONE) begin
                miso <= 1'b0;
            end else if (load) begin
                miso <= rd_word[DATA_WIDTH-1];
                tx <= rd_word << 1;
            end else if (state == RDATA) begin
                miso <= tx[DATA_WIDTH-1];
                tx <= tx << 1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= sh_nx[DATA_WIDTH-1:0];
    end
endmodule

// File: tb/tb_spi_slave_burst_ram.sv
// tb_spi_slave_burst_ram: directed self-checking bench for spi_slave_burst_ram (auto-increment and fixed-pointer builds)
module tb_spi_slave_burst_ram;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ss = 1'b1;
    logic mosi = 1'b0;
    logic sel = 1'b0;
    int n = 0;
    int errs = 0;
    logic [15:0] word;
    spi_slave_burst_ram_if ifa ();
    spi_slave_burst_ram_if ifb ();
    assign ifa.SS_n = sel ? 1'b1 : ss;
    assign ifb.SS_n = sel ? ss : 1'b1;
    assign ifa.MOSI = mosi;
    assign ifb.MOSI = mosi;
    wire miso = sel ? ifb.MISO : ifa.MISO;
    wire busy = sel ? ifb.busy : ifa.busy;
    spi_slave_burst_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    spi_slave_burst_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .AUTO_INC(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic s, input logic m);
        @(negedge clk);
        ss = s;
        mosi = m;
        @(posedge clk);
        #1;
    endtask
    task automatic start(input logic [1:0] op);
        step(1'b0, 1'b0);
        step(1'b0, op[1]);
        step(1'b0, op[0]);
    endtask
    task automatic send(input logic [7:0] v, input int nb);
        for (int i = 7; i > 7 - nb; i--) step(1'b0, v[i]);
    endtask
    task automatic stop();
        step(1'b1, 1'b0);
    endtask
    task automatic read16();
        start(2'b11);
        word[15] = miso;
        for (int i = 14; i >= 0; i--) begin
            step(1'b0, 1'b0);
            word[i] = miso;
        end
        stop();
    endtask
    initial begin
        #3;
        chk("reset_miso", 32'(miso), 32'(1'b0));
        chk("reset_busy", 32'(busy), 32'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        chk("busy_opc", 32'(busy), 32'(1'b1));
        stop();
        chk("min_frame_idle", 32'(busy), 32'(1'b0));
        chk("min_frame_wr_ptr", 32'(dut_a.wr_ptr), 32'h00);
        start(2'b00); send(8'h0F, 8);
        chk("waddr_done_busy", 32'(busy), 32'(1'b1));
        stop();
        chk("waddr_ptr", 32'(dut_a.wr_ptr), 32'h0F);
        start(2'b01); send(8'hAB, 8); send(8'hCD, 8); stop();
        chk("burst_mem0f", 32'(dut_a.mem[8'h0F]), 32'hAB);
        chk("burst_mem10", 32'(dut_a.mem[8'h10]), 32'hCD);
        chk("burst_wr_ptr", 32'(dut_a.wr_ptr), 32'h11);
        start(2'b10); send(8'h0F, 8); stop();
        chk("raddr_ptr", 32'(dut_a.rd_ptr), 32'h0F);
        chk("raddr_keeps_wr", 32'(dut_a.wr_ptr), 32'h11);
        start(2'b11);
        word[15] = miso;
        chk("rd_bit15", 32'(miso), 32'(1'b1));
        for (int i = 14; i >= 0; i--) begin
            step(1'b0, 1'b0);
            word[i] = miso;
        end
        chk("rd_stream", 32'(word), 32'hABCD);
        stop();
        chk("rd_end_miso", 32'(miso), 32'(1'b0));
        chk("rd_end_ptr", 32'(dut_a.rd_ptr), 32'h11);
        start(2'b00); send(8'hFF, 8); stop();
        start(2'b01); send(8'h11, 8); send(8'h22, 8); stop();
        chk("wrap_memff", 32'(dut_a.mem[8'hFF]), 32'h11);
        chk("wrap_mem00", 32'(dut_a.mem[8'h00]), 32'h22);
        chk("wrap_wr_ptr", 32'(dut_a.wr_ptr), 32'h01);
        start(2'b00); send(8'h40, 8); stop();
        start(2'b01); send(8'h3C, 8); stop();
        start(2'b00); send(8'h40, 8); stop();
        start(2'b01); send(8'hF0, 5); stop();
        chk("abort_mem", 32'(dut_a.mem[8'h40]), 32'h3C);
        chk("abort_wr_ptr", 32'(dut_a.wr_ptr), 32'h40);
        start(2'b01); send(8'h77, 8); stop();
        chk("post_abort_mem", 32'(dut_a.mem[8'h40]), 32'h77);
        chk("post_abort_ptr", 32'(dut_a.wr_ptr), 32'h41);
        start(2'b10); send(8'h0F, 8); stop();
        start(2'b11);
        chk("pre_rst_miso", 32'(miso), 32'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_miso", 32'(miso), 32'(1'b0));
        chk("async_rst_busy", 32'(busy), 32'(1'b0));
        chk("async_rst_ptr", 32'(dut_a.rd_ptr), 32'h00);
        @(negedge clk);
        ss = 1'b1;
        rst_n = 1'b1;
        sel = 1'b1;
        start(2'b00); send(8'h20, 8); stop();
        start(2'b01); send(8'h55, 8); send(8'h66, 8); stop();
        chk("fixed_mem20", 32'(dut_b.mem[8'h20]), 32'h66);
        chk("fixed_wr_ptr", 32'(dut_b.wr_ptr), 32'h20);
        start(2'b10); send(8'h20, 8); stop();
        read16();
        chk("fixed_rd_stream", 32'(word), 32'h6666);
        chk("fixed_rd_ptr", 32'(dut_b.rd_ptr), 32'h20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
        $finish;
    end
endmodule

// File: doc/spi_slave_burst_ram.md
Name: spi_slave_burst_ram

Overview:
Parametrised successor to the single-word SPI-slave/RAM wrapper. It combines an SPI slave front end and an internal single-port memory behind one system clock. It adds configurable address and data widths, and burst transfers with address auto-increment and wrap. Back-to-back read words are streamed on MISO with no gap cycles. It sits behind the chip-level SPI pins; MOSI and SS_n are already synchronous to clk.

Parameters:
ADDR_WIDTH, 8, address bits; memory depth is 2**ADDR_WIDTH words.
DATA_WIDTH, 8, bits per memory word and per SPI data word.
AUTO_INC, 1, 1 = pointer increments after every word in a data burst; 0 = pointer fixed (repeated access to one word).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
SS_n  input  1  slave select, active low; frames a transaction.
MOSI  input  1  serial data in, MSB first, sampled on rising clk while SS_n=0.
MISO  output  1  serial data out, registered, MSB first.
busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, any time): state=IDLE, MISO=0, busy=0, wr_ptr=0, rd_ptr=0, shift and bit counters cleared.
  - Memory contents are not reset; they are X until written or preloaded by the bench.
- States: IDLE, OPC, WADDR, WDATA, RADDR, RDATA, DONE.
- IDLE: on an edge with SS_n=0, go to OPC. MOSI is not sampled on this edge (edge E0).
- OPC: samples 2 opcode bits at edges E1 and E2, MSB first. Decode at E2:
  - 00 -> WADDR
  - 01 -> WDATA
  - 10 -> RADDR
  - 11 -> RDATA
- WADDR / RADDR:
  - Shift in ADDR_WIDTH bits.
  - On the edge sampling the last bit, load wr_ptr / rd_ptr with the assembled value, then go to DONE.
- WDATA:
  - Shift in DATA_WIDTH bits per word.
  - On the edge sampling the last bit, write mem[wr_ptr] with the word. If AUTO_INC, wr_ptr <= wr_ptr+1 modulo 2**ADDR_WIDTH in the same edge.
  - The bit counter restarts; the next word follows immediately.
- RDATA:
  - At E2 (opcode decode edge): MISO <= mem[rd_ptr][DATA_WIDTH-1]; the remaining bits go to the tx shift register. If AUTO_INC, rd_ptr increments.
  - Each following edge shifts out the next bit.
  - The edge after the LSB was presented reloads the next word (MISO <= new MSB) and increments rd_ptr again. The stream is continuous with no idle bit.
  - MOSI is ignored in RDATA.
- DONE: ignores MOSI; MISO=0; waits for SS_n.
- SS_n=1 sampled in any non-IDLE state: next state IDLE, MISO <= 0, partial word discarded.
  - Completed writes are retained.
  - Pointers keep their last committed values, including increments for words already loaded for transmit.
- Write and read pointers are independent; a read-address frame does not disturb wr_ptr, and vice versa.
- Memory reads are combinational from internal registers; no extra read latency is visible at MISO.
- Read of a never-written location returns X (the bench must preload before checking).
- SS_n held low with no clock activity: state is held. Minimum frame is one low sample; IDLE->OPC->IDLE is legal and has no side effects.

Test Plan (ADDR_WIDTH=8, DATA_WIDTH=8, AUTO_INC=1 unless stated):
- Reset: rst_n=0 mid-stream -> MISO=0 and busy=0 immediately (async), without waiting for a clk edge.
- Write burst: frame opcode 00 + 0x0F; then frame opcode 01 + 0xAB + 0xCD -> mem[0x0F]=0xAB, mem[0x10]=0xCD, wr_ptr=0x11.
- Read burst: frame opcode 10 + 0x0F; then frame opcode 11 held 16 cycles -> MISO = 1,0,1,0,1,0,1,1,1,1,0,0,1,1,0,1.
  - The first bit is valid after E2; there is no gap between words; rd_ptr=0x11 after the frame.
- Wrap: write address 0xFF, burst 0x11, 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22, wr_ptr=0x01.
- Abort: write-data frame with SS_n raised after 5 data bits -> no memory write, wr_ptr unchanged. The next full frame writes correctly.
- AUTO_INC=0 build: burst 0x55, 0x66 at address 0x20 -> mem[0x20]=0x66, mem[0x21] untouched. A 16-cycle read returns 0x66 twice.
